control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main control decoder for the single-issue RV32I datapath. Decodes the 7-bit opcode
//  into datapath steering and enable signals: ALU operand select, writeback select,
//  register-file write, data-memory read/write, branch, and the 2-bit ALUOp for the
//  ALU-control block. Sits between instruction fetch/decode and the execute/memory
//  stages. Outputs are registered.
// PARAMETERS
//  none (opcode and ALUOp encodings are fixed constants, see STRUCTURE)
// PORTS
//  One clock; reset is synchronous and active-high.
//  clk       in   1  rising-edge clock
//  rst       in   1  synchronous, active-high reset
//  Input     in   7  instruction opcode field, instr[6:0]
//  ALUSrc    out  1  0 = ALU operand B from rs2; 1 = from immediate
//  MemtoReg  out  1  0 = writeback from ALU; 1 = from data memory
//  RegWrite  out  1  register-file write enable
//  MemRead   out  1  data-memory read enable
//  MemWrite  out  1  data-memory write enable
//  Branch    out  1  conditional-branch instruction
//  ALUOp     out  2  00 add (addr), 01 sub/compare (branch), 10 R-type funct, 11 I-type funct
//  Illegal   out  1  opcode not in the supported set
// BEHAVIOUR
//  - Combinational decode of Input; all outputs registered on rising clk; latency 1 cycle.
//  - rst=1 at a rising edge: every output <= 0 (ALUOp=00, Illegal=0); takes priority over decode.
//  - Decode table (ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp Illegal):
//      0110011 R-type : 0 0 1 0 0 0 10 0
//      0010011 I-ALU  : 1 0 1 0 0 0 11 0
//      0000011 load   : 1 1 1 1 0 0 00 0
//      0100011 store  : 1 0 0 0 1 0 00 0
//      1100011 branch : 0 0 0 0 0 1 01 0
//      any other      : 0 0 0 0 0 0 00 1
//  - Don't-care fields (MemtoReg for store/branch) are driven 0, never X.
//  - Unsupported/illegal opcode: no write/read/branch enables asserted (safe NOP).
//  - At most one of MemRead/MemWrite is ever 1; RegWrite and MemWrite never both 1.
//  - Input with X/Z bits decodes as illegal (default branch of the case).
//  - Opcode change every cycle: each registered output reflects the opcode sampled
//    at the previous edge only; no state carried between instructions.
// STRUCTURE
//  - Shared package ctrl_pkg: opcode constants (OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE,
//    OP_BRANCH) and ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ITYPE).
//  - One sub-module: control_decode (pure combinational opcode -> control bundle);
//    control_unit wraps it with the output register and reset.
// TESTING
//  - rst=1 for 2 cycles with Input=0110011 -> all outputs 0, Illegal=0.
//  - Input=0100011, one edge -> ALUSrc=1 MemtoReg=0 RegWrite=0 MemRead=0 MemWrite=1 Branch=0 ALUOp=00.
//  - Input=1100011, one edge -> ALUSrc=0 MemtoReg=0 RegWrite=0 MemRead=0 MemWrite=0 Branch=1 ALUOp=01.
//  - Input=0000011 then 0110011 back-to-back -> load row (1 1 1 1 0 0 00) then R row (0 0 1 0 0 0 10), one cycle apart.
//  - Input=1111111 -> all enables 0, ALUOp=00, Illegal=1; Input=0010011 next -> 1 0 1 0 0 0 11, Illegal=0.
//  - rst asserted mid-stream while Input=0000011 -> outputs 0 at that edge; decode resumes the edge after rst drops.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode constants and the control bundle carried from decoder to output register.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode -> control bundle decode.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    // Start from an all-zero (safe NOP) bundle and enable only what each class needs;
    // anything unrecognised, including X/Z opcodes, falls to the illegal default.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_RTYPE;
            end
            OP_IALU: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_ITYPE;
            end
            OP_LOAD: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.aluop    = ALUOP_SUB;
            end
            default: begin
                ctrl.illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main control decoder: combinational decode followed by a single output register.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Input,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       Illegal
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (Input),
        .ctrl   (ctrl_d)
    );

    // Register the decoded bundle; reset clears everything and overrides decode.
    always_ff @(posedge clk) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= ctrl_d;
    end

    assign ALUSrc   = ctrl_q.alusrc;
    assign MemtoReg = ctrl_q.memtoreg;
    assign RegWrite = ctrl_q.regwrite;
    assign MemRead  = ctrl_q.memread;
    assign MemWrite = ctrl_q.memwrite;
    assign Branch   = ctrl_q.branch;
    assign ALUOp    = ctrl_q.aluop;
    assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases then randomized opcode/reset stream.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] Input;
    logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Illegal;
    logic [1:0] ALUOp;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .Input    (Input),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .Illegal  (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table: {ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp Illegal}
    logic [6:0] ref_op  [5];
    logic [8:0] ref_row [5];
    initial begin
        ref_op[0] = 7'b0110011; ref_row[0] = 9'b0_0_1_0_0_0_10_0;
        ref_op[1] = 7'b0010011; ref_row[1] = 9'b1_0_1_0_0_0_11_0;
        ref_op[2] = 7'b0000011; ref_row[2] = 9'b1_1_1_1_0_0_00_0;
        ref_op[3] = 7'b0100011; ref_row[3] = 9'b1_0_0_0_1_0_00_0;
        ref_op[4] = 7'b1100011; ref_row[4] = 9'b0_0_0_0_0_1_01_0;
    end

    function automatic logic [8:0] model(input logic r, input logic [6:0] op);
        logic [8:0] v;
        v = 9'b0_0_0_0_0_0_00_1;
        if (r) return 9'b0;
        for (int i = 0; i < 5; i++)
            if (ref_op[i] == op) v = ref_row[i];
        return v;
    endfunction

    function automatic logic [8:0] observed();
        return {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal};
    endfunction

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then check the registered result just after the edge.
    task automatic step(input string tag, input logic r, input logic [6:0] op);
        logic [8:0] o;
        rst   = r;
        Input = op;
        @(posedge clk);
        #1;
        o = observed();
        chk(tag, o, model(r, op));
        chk({tag, "_rdwr"}, {8'b0, MemRead & MemWrite}, 9'b0);
        chk({tag, "_rwmw"}, {8'b0, RegWrite & MemWrite}, 9'b0);
    endtask

    initial begin
        logic [6:0] op;
        logic       r;
        rst   = 1'b1;
        Input = 7'b0110011;
        @(posedge clk);
        #1;
        step("reset", 1'b1, 7'b0110011);
        step("store", 1'b0, 7'b0100011);
        step("branch", 1'b0, 7'b1100011);
        step("load", 1'b0, 7'b0000011);
        step("rtype_after_load", 1'b0, 7'b0110011);
        step("illegal_ff", 1'b0, 7'b1111111);
        step("ialu_after_illegal", 1'b0, 7'b0010011);
        step("load_pre_rst", 1'b0, 7'b0000011);
        step("rst_midstream", 1'b1, 7'b0000011);
        step("load_post_rst", 1'b0, 7'b0000011);
        step("illegal_zero", 1'b0, 7'b0000000);
        step("illegal_near_rtype", 1'b0, 7'b0110111);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1, 0) == 1) op = ref_op[$urandom_range(4, 0)];
            else                           op = 7'($urandom);
            r = ($urandom_range(19, 0) == 0);
            step("rand", r, op);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
